// File: rtl/uv_sram_ctrl.sv
// Slave controller driving a 1-cycle-latency single-port SRAM, responses buffered in a small FIFO.
// Optional macro UV_SRAM_RANGE_CHK_EN enables out-of-range access-fault reporting.
module uv_sram_ctrl #(
  parameter int unsigned ALEN         = 32,
  parameter int unsigned DLEN         = 32,
  parameter int unsigned MLEN         = DLEN / 8,
  parameter int unsigned AW           = 12,
  parameter int unsigned MEM_BASE_LSB = 31,
  parameter int unsigned RSP_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_read,
  input  logic [ALEN-1:0]  req_addr,
  input  logic [MLEN-1:0]  req_mask,
  input  logic [DLEN-1:0]  req_data,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [1:0]       rsp_excp,
  output logic [DLEN-1:0]  rsp_data,
  output logic             sram_ce,
  output logic             sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [MLEN-1:0]  sram_wem,
  output logic [DLEN-1:0]  sram_wdata,
  input  logic [DLEN-1:0]  sram_rdata
);

  localparam int unsigned MB = $clog2(MLEN);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic            w_accept;
  logic            w_fault;
  logic            w_vld;
  logic            w_pop;
  logic [OW-1:0]   w_occ;
  logic [DLEN-1:0] w_push_data;
  logic [1:0]      w_push_excp;
  logic            w_unused_addr;

  logic            r_inflight;
  logic            r_infl_read;
  logic            r_infl_fault;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic [DLEN-1:0] r_fifo_data [RSP_DEPTH];
  logic [1:0]      r_fifo_excp [RSP_DEPTH];

`ifdef UV_SRAM_RANGE_CHK_EN
  assign w_fault = |req_addr[MEM_BASE_LSB-1:AW+MB];
`else
  assign w_fault = 1'b0;
`endif

  // Address bits outside the word index are intentionally ignored.
  assign w_unused_addr = ^req_addr;

  // Occupancy counts the inflight slot so the SRAM is only accessed with a guaranteed FIFO slot.
  assign w_vld    = ~rst & (r_cnt != '0);
  assign w_pop    = w_vld & rsp_rdy;
  assign w_occ    = OW'(r_cnt) + OW'(r_inflight);
  assign req_rdy  = ~rst & ((w_occ - OW'(w_pop)) < OW'(RSP_DEPTH));
  assign w_accept = req_vld & req_rdy;

  assign sram_ce    = w_accept & ~w_fault;
  assign sram_we    = ~req_read;
  assign sram_addr  = req_addr[AW+MB-1:MB];
  assign sram_wem   = req_mask;
  assign sram_wdata = req_data;

  assign w_push_data = (r_infl_read & ~r_infl_fault) ? sram_rdata : '0;
  assign w_push_excp = r_infl_fault ? 2'b01 : 2'b00;

  assign rsp_vld  = w_vld;
  assign rsp_data = w_vld ? r_fifo_data[r_rptr] : '0;
  assign rsp_excp = w_vld ? r_fifo_excp[r_rptr] : 2'b00;

  // Control state: inflight tracker, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight   <= 1'b0;
      r_infl_read  <= 1'b0;
      r_infl_fault <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
    end else begin
      r_inflight   <= w_accept;
      r_infl_read  <= req_read;
      r_infl_fault <= w_fault;
      if (r_inflight) begin
        r_wptr <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      end
      case ({r_inflight, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage needs no reset; entries are qualified by r_cnt.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_excp[r_wptr] <= w_push_excp;
    end
  end

endmodule

// File: tb/tb_uv_sram_ctrl.sv
// Randomized self-checking bench for uv_sram_ctrl against a transaction-level reference model.
module tb_uv_sram_ctrl;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_read;
  logic [31:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [1:0]  rsp_excp;
  logic [31:0] rsp_data;
  logic        sram_ce;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [3:0]  sram_wem;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  uv_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_read   (req_read),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_data   (req_data),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_excp   (rsp_excp),
    .rsp_data   (rsp_data),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wem   (sram_wem),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with 1-cycle read latency.
  logic [31:0] sram_mem [4096];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wem[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  excp;
    int          acc;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] ref_mem [4096];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic [31:0] last_rsp;
  logic [1:0]  last_excp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic fault_of(input logic [31:0] a);
`ifdef UV_SRAM_RANGE_CHK_EN
    return (a & 32'h7FFF_C000) != 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: check outputs at the falling edge, update the model, advance.
  task automatic cyc();
    logic  ev, er, acc, flt;
    int    w;
    rsp_t  r;
    #4;
    if (rst) begin
      chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
      chk("rst_req_rdy", 64'(req_rdy), 64'd0);
      chk("rst_sram_ce", 64'(sram_ce), 64'd0);
      chk("rst_rsp_excp", 64'(rsp_excp), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    end else begin
      ev = (q.size() > 0) && (cyc_n >= q[0].acc + 2);
      chk("rsp_vld", 64'(rsp_vld), 64'(ev));
      er = (q.size() - ((ev && rsp_rdy) ? 1 : 0)) < DEPTH;
      chk("req_rdy", 64'(req_rdy), 64'(er));
      acc = req_vld && er;
      flt = fault_of(req_addr);
      w   = int'((req_addr >> 2) % 4096);
      chk("sram_ce", 64'(sram_ce), 64'(acc && !flt));
      if (acc && !flt) begin
        chk("sram_addr", 64'(sram_addr), 64'(w));
        chk("sram_we", 64'(sram_we), 64'(!req_read));
        if (!req_read) chk("sram_wem", 64'(sram_wem), 64'(req_mask));
      end
      if (ev) begin
        chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
        chk("rsp_excp", 64'(rsp_excp), 64'(q[0].excp));
        if (rsp_rdy) begin
          last_rsp  = q[0].data;
          last_excp = q[0].excp;
          n_pop++;
          void'(q.pop_front());
        end
      end
      if (acc) begin
        n_acc++;
        r.acc  = cyc_n;
        r.excp = flt ? 2'b01 : 2'b00;
        r.data = 32'h0;
        if (!flt) begin
          if (req_read) r.data = ref_mem[w];
          else for (int b = 0; b < 4; b++)
            if (req_mask[b]) ref_mem[w][8*b +: 8] = req_data[8*b +: 8];
        end
        q.push_back(r);
      end
    end
    @(posedge clk);
    if (rst) q.delete();
    cyc_n++;
    #1;
  endtask

  task automatic req(input logic rd, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    req_vld  = 1'b1;
    req_read = rd;
    req_addr = a;
    req_mask = m;
    req_data = d;
    cyc();
    req_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    req_vld = 1'b0;
    repeat (n) cyc();
  endtask

  int a0, p0;
  logic [31:0] exp_oor;

  initial begin
    rst = 1'b1; req_vld = 1'b1; req_read = 1'b1; req_addr = '0;
    req_mask = '0; req_data = '0; rsp_rdy = 1'b1;
    @(posedge clk); #1;
    repeat (2) cyc();
    rst = 1'b0;
    idle(1);

    // Preload words 0..63 through the DUT.
    for (int i = 0; i < 64; i++) req(1'b0, 32'(i * 4), 4'hF, $urandom);
    idle(3);

    req(1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    idle(3);
    req(1'b1, 32'h10, 4'h0, 32'h0);
    idle(3);
    chk("t1_read_back", 64'(last_rsp), 64'hDEADBEEF);

    req(1'b0, 32'h20, 4'hF, 32'h11223344);
    req(1'b0, 32'h20, 4'h1, 32'h000000AA);
    req(1'b1, 32'h20, 4'h0, 32'h0);
    idle(3);
    chk("t2_mask_merge", 64'(last_rsp), 64'h112233AA);

    a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 4; i++) req(1'b1, 32'(i * 4), 4'h0, 32'h0);
    idle(3);
    chk("t3_b2b_accepts", 64'(n_acc - a0), 64'd4);
    chk("t3_b2b_pops", 64'(n_pop - p0), 64'd4);

    rsp_rdy = 1'b0;
    a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 6; i++) req(1'b1, 32'(16 + i * 4), 4'h0, 32'h0);
    chk("t4_stall_accepts", 64'(n_acc - a0), 64'd2);
    rsp_rdy = 1'b1;
    idle(4);
    chk("t4_stall_pops", 64'(n_pop - p0), 64'd2);

    req(1'b1, 32'h4000, 4'h0, 32'h0);
    idle(3);
`ifdef UV_SRAM_RANGE_CHK_EN
    exp_oor = 32'h0;
    chk("t5_oor_excp", 64'(last_excp), 64'd1);
`else
    exp_oor = ref_mem[0];
    chk("t5_oor_excp", 64'(last_excp), 64'd0);
`endif
    chk("t5_oor_data", 64'(last_rsp), 64'(exp_oor));

    rsp_rdy = 1'b0;
    req(1'b1, 32'h8, 4'h0, 32'h0);
    req(1'b1, 32'hC, 4'h0, 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_rdy = 1'b1;
    p0 = n_pop;
    idle(4);
    chk("t6_no_stale_rsp", 64'(n_pop - p0), 64'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 14);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      rst      = ($urandom_range(0, 99) == 0);
      rsp_rdy  = ($urandom_range(0, 3) != 0);
      req_vld  = ($urandom_range(0, 3) != 0);
      req_read = $urandom_range(0, 1) == 1;
      req_addr = a;
      req_mask = 4'($urandom_range(0, 15));
      req_data = $urandom;
      cyc();
    end
    rst = 1'b0;
    rsp_rdy = 1'b1;
    idle(5);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
